// File: rtl/smart_vending_machine.sv
// Vending controller: accepts one payment in IDLE, vends one or more products
// from the credit, then returns change or refunds on insufficient funds.
module smart_vending_machine (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] money_inserted,
  input  logic [1:0] product_select,
  input  logic       buy_more,
  output logic [7:0] change,
  output logic       dispense,
  output logic       insufficient
);

  typedef enum logic [2:0] {IDLE, CHECK, VEND, CHANGE, REJECT} state_t;

  state_t     state, state_nxt;
  logic [7:0] credit, credit_nxt;
  logic [7:0] price, price_nxt;
  logic [7:0] change_nxt;
  logic       dispense_nxt, insufficient_nxt;
  logic [7:0] sel_price;

  always_comb begin
    unique case (product_select)
      2'b00:   sel_price = 8'd25;
      2'b01:   sel_price = 8'd50;
      2'b10:   sel_price = 8'd75;
      default: sel_price = 8'd100;
    endcase
  end

  // Outputs are computed one state ahead and registered, so each pulse lines
  // up with the state it belongs to.
  always_comb begin
    state_nxt        = state;
    credit_nxt       = credit;
    price_nxt        = price;
    change_nxt       = 8'd0;
    dispense_nxt     = 1'b0;
    insufficient_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (money_inserted != 8'd0) begin
          credit_nxt = money_inserted;
          price_nxt  = sel_price;
          state_nxt  = CHECK;
        end
      end
      CHECK: begin
        if (credit >= price) begin
          credit_nxt   = credit - price;
          dispense_nxt = 1'b1;
          state_nxt    = VEND;
        end else begin
          insufficient_nxt = 1'b1;
          change_nxt       = credit;
          credit_nxt       = 8'd0;
          state_nxt        = REJECT;
        end
      end
      VEND: begin
        // Repeat purchase only if it is already known to be affordable.
        if (buy_more && credit >= sel_price) begin
          price_nxt = sel_price;
          state_nxt = CHECK;
        end else begin
          change_nxt = credit;
          credit_nxt = 8'd0;
          state_nxt  = CHANGE;
        end
      end
      CHANGE:  state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      credit       <= 8'd0;
      price        <= 8'd0;
      change       <= 8'd0;
      dispense     <= 1'b0;
      insufficient <= 1'b0;
    end else begin
      state        <= state_nxt;
      credit       <= credit_nxt;
      price        <= price_nxt;
      change       <= change_nxt;
      dispense     <= dispense_nxt;
      insufficient <= insufficient_nxt;
    end
  end

endmodule

// File: tb/tb_smart_vending_machine.sv
// Scoreboard bench: each transaction pushes its expected per-cycle outputs,
// which are popped and compared on falling edges as the DUT runs.
module tb_smart_vending_machine;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] money_inserted;
  logic [1:0] product_select;
  logic       buy_more;
  logic [7:0] change;
  logic       dispense;
  logic       insufficient;

  typedef struct packed {
    logic       d;
    logic       i;
    logic [7:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  smart_vending_machine dut (
    .clk            (clk),
    .reset          (reset),
    .money_inserted (money_inserted),
    .product_select (product_select),
    .buy_more       (buy_more),
    .change         (change),
    .dispense       (dispense),
    .insufficient   (insufficient)
  );

  always #5 clk = ~clk;

  // Expected sequence from the first cycle after the accept edge to the
  // first IDLE cycle after completion.
  task automatic push_model(input int money, input int sel, input bit bm);
    int p, k;
    exp_t e;
    p = 25 * (sel + 1);
    if (money < p) begin
      exp_q.push_back('{d: 1'b0, i: 1'b0, c: 8'd0});
      e = '{d: 1'b0, i: 1'b1, c: money[7:0]};
      exp_q.push_back(e);
    end else begin
      k = bm ? money / p : 1;
      for (int n = 0; n < k; n++) begin
        exp_q.push_back('{d: 1'b0, i: 1'b0, c: 8'd0});
        exp_q.push_back('{d: 1'b1, i: 1'b0, c: 8'd0});
      end
      e = '{d: 1'b0, i: 1'b0, c: 8'(money - k * p)};
      exp_q.push_back(e);
    end
    exp_q.push_back('{d: 1'b0, i: 1'b0, c: 8'd0});
  endtask

  task automatic run_txn(input int money, input int sel, input bit bm, input string name);
    exp_t e;
    int   cyc;
    push_model(money, sel, bm);
    @(negedge clk);
    money_inserted = money[7:0];
    product_select = sel[1:0];
    buy_more       = bm;
    @(posedge clk);
    @(negedge clk);
    money_inserted = 8'd0;
    cyc = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({dispense, insufficient, change} !== {e.d, e.i, e.c}) begin
        fails++;
        $display("FAIL %s cyc%0d: got d=%b i=%b c=%0d, want d=%b i=%b c=%0d",
                 name, cyc, dispense, insufficient, change, e.d, e.i, e.c);
      end
      cyc++;
      if (exp_q.size() > 0) @(negedge clk);
    end
    buy_more = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    money_inserted = 8'd0;
    product_select = 2'b00;
    buy_more       = 1'b0;
    #3;
    tests++;
    if ({dispense, insufficient, change} !== 10'd0) begin
      fails++;
      $display("FAIL reset_state: got d=%b i=%b c=%0d, want all 0", dispense, insufficient, change);
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_single();
    run_txn(25, 0, 1'b0, "exact_25");
    run_txn(100, 2, 1'b0, "vend75_chg25");
    run_txn(100, 3, 1'b0, "exact_100");
    run_txn(200, 1, 1'b0, "vend50_chg150");
  endtask

  task automatic test_reject();
    run_txn(25, 1, 1'b0, "reject_25_for_50");
    run_txn(10, 0, 1'b0, "reject_10");
    run_txn(99, 3, 1'b1, "reject_99_for_100");
  endtask

  task automatic test_buy_more();
    run_txn(50, 1, 1'b1, "bm_50_one_vend");
    run_txn(100, 0, 1'b1, "bm_four_vends");
    run_txn(255, 3, 1'b1, "bm_255_two_vends");
    run_txn(80, 0, 1'b1, "bm_80_three_vends");
  endtask

  task automatic test_reset_mid_vend();
    int guard;
    @(negedge clk);
    money_inserted = 8'd100;
    product_select = 2'b10;
    buy_more       = 1'b0;
    @(posedge clk);
    @(negedge clk);
    money_inserted = 8'd0;
    guard = 0;
    while (dispense !== 1'b1 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    tests++;
    if (dispense !== 1'b1) begin
      fails++;
      $display("FAIL mid_vend_reach: dispense never seen within %0d cycles", guard);
    end
    #2 reset = 1'b1;
    #1;
    tests++;
    if ({dispense, insufficient, change} !== 10'd0) begin
      fails++;
      $display("FAIL async_reset: got d=%b i=%b c=%0d, want all 0", dispense, insufficient, change);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      tests++;
      if ({dispense, insufficient, change} !== 10'd0) begin
        fails++;
        $display("FAIL post_reset_quiet cyc%0d: got d=%b i=%b c=%0d, want all 0",
                 n, dispense, insufficient, change);
      end
    end
    run_txn(75, 2, 1'b0, "after_reset_exact_75");
  endtask

  task automatic test_back_to_back();
    run_txn(30, 0, 1'b0, "b2b_a");
    run_txn(40, 3, 1'b0, "b2b_b");
    run_txn(150, 2, 1'b1, "b2b_c");
  endtask

  initial begin
    test_reset();
    test_single();
    test_reject();
    test_buy_more();
    test_reset_mid_vend();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/smart_vending_machine.md
SMART_VENDING_MACHINE -- requirements
Module: smart_vending_machine

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  input  1  system clock; all state and outputs update on the rising edge.
REQ-003 reset  input  1  asynchronous active-high reset.
REQ-004 money_inserted  input  8  amount offered for one transaction, unsigned; 0 means no money offered.
REQ-005 product_select  input  2  product code: 00=25, 01=50, 10=75, 11=100.
REQ-006 buy_more  input  1  request another product from the remaining credit after a dispense.
REQ-007 change  output  8  refund or change amount; valid only in the completion cycle, 0 otherwise.
REQ-008 dispense  output  1  high for exactly one cycle per product vended.
REQ-009 insufficient  output  1  high for one cycle when the credit is below the selected price.

Function
REQ-010 All outputs SHALL be registered, with no combinational path from inputs to outputs.
REQ-011 State machine states SHALL be IDLE, CHECK, VEND, CHANGE and REJECT.
REQ-012 Internal registers SHALL be an 8-bit credit and an 8-bit price.
REQ-013 IDLE with money_inserted != 0: credit <= money_inserted, price <= price(product_select), go to CHECK.
REQ-014 IDLE with money_inserted == 0: stay in IDLE; outputs 0.
REQ-015 CHECK with credit >= price: credit <= credit - price, dispense <= 1, go to VEND.
REQ-016 CHECK with credit < price: insufficient <= 1, change <= credit (full refund), credit <= 0, go to REJECT.
REQ-017 VEND with buy_more=1 and credit >= price(current product_select): price <= new price, go to CHECK (dispense low for that cycle).
REQ-018 VEND otherwise: change <= credit, credit <= 0, go to CHANGE.
REQ-019 CHANGE and REJECT SHALL each last one cycle, then go to IDLE.
REQ-020 Outputs are nonzero only as follows: dispense in VEND; change in CHANGE/REJECT; insufficient in REJECT.
REQ-021 The equality case credit == price SHALL vend with change 0.
REQ-022 Subtraction SHALL never underflow, because it is performed only after the >= check; credit stays 8-bit with no wrap.
REQ-023 Inputs SHALL be ignored outside IDLE, except buy_more and product_select in VEND.
REQ-024 A held nonzero money_inserted SHALL start a new transaction on the first IDLE cycle after completion; the environment drops it to 0 to avoid repeats.
REQ-025 A single-purchase transaction SHALL take 4 cycles from the IDLE accept edge to the return to IDLE.
REQ-026 A rejected transaction SHALL take 3 cycles.

Reset
REQ-027 On reset assertion (asynchronous), the state SHALL go to IDLE immediately.
REQ-028 On reset assertion, credit, price, change, dispense and insufficient SHALL all clear to 0.
REQ-029 Reset mid-transaction SHALL discard the credit with no refund output.
REQ-030 Reset deassertion SHALL be synchronous-safe; the first accept occurs on the first rising edge after release.

Verification
REQ-031 sel=00, money=25, buy_more=0 -> dispense pulse 1 cycle, then change=0 pulse, insufficient never high.
REQ-032 sel=01, money=25 -> insufficient=1 and change=25 in the same cycle, dispense never high.
REQ-033 sel=10, money=100 -> dispense pulse, next cycle change=25.
REQ-034 sel=01, money=50, buy_more=1 -> one dispense, no second vend (credit 0 < 50), change=0, returns to IDLE.
REQ-035 sel=00, money=100, buy_more=1 held -> four dispense pulses, then change=0; sel=00, money=10 -> insufficient with change=10.
REQ-036 Reset asserted during VEND -> all outputs 0 asynchronously, state IDLE, no change pulse after release.
